// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky pending queue and valid/ready output.
// Optional per-index arbitration mask enabled by defining PRIO_ENC_MASK_EN.
module prio_encoder_q #(
   parameter int unsigned N     = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
`ifdef PRIO_ENC_MASK_EN
   input  logic [N-1:0]     mask,
`endif
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   input  logic             out_ready,
   output logic [N-1:0]     pend,
   output logic             overflow
);

   generate
      if (N < 2 || N > 64 || IDX_W != $clog2(N)) begin : g_bad_cfg
         $error("prio_encoder_q: N must be 2..64 and IDX_W must equal $clog2(N)");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             valid_d;
   logic [IDX_W-1:0] idx_d;
   logic [N-1:0]     clr;
   logic [N-1:0]     elig;
   logic [IDX_W-1:0] win;
   logic             ack;

   assign ack = out_valid & out_ready;

   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < N; i++) begin
         clr[i] = ack && (out_idx == IDX_W'(i));
      end
   end

`ifdef PRIO_ENC_MASK_EN
   assign elig = pend & ~clr & ~mask;
`else
   assign elig = pend & ~clr;
`endif

   // Ascending scan: the last hit is the highest set index.
   always_comb begin
      win = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (elig[i]) begin
            win = IDX_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = out_valid;
      idx_d   = out_idx;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (elig != '0) begin
               state_d = GRANT;
               valid_d = 1'b1;
               idx_d   = win;
            end
         end
         GRANT: begin
            if (ack) begin
               if (elig != '0) begin
                  idx_d = win;
               end else begin
                  state_d = IDLE;
                  valid_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
         out_idx   <= '0;
         pend      <= '0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_valid <= valid_d;
         out_idx   <= idx_d;
         // Set wins over the acknowledge clear.
         pend      <= (pend & ~clr) | req;
         overflow  <= |(req & pend & ~clr);
      end
   end

endmodule
